param_bus_datapath: RTL and testbench
=====================================

Name: param_bus_datapath

Overview:
Parametrised successor to the single-bus CPU datapath. It provides a GPR file of configurable width and depth, the special registers (HI, LO, PC, IR, Y, MAR, MDR, ZHI, ZLO) and a one-hot bus mux with conflict detection. Its ALU has a start/busy/done handshake: single-cycle logic/arith ops, plus multi-cycle signed multiply and divide. The control unit drives all enables; memory connects through MAR/MDR.

Parameters:
DATA_W, 32, datapath width in bits (power of 2, >=8)
NUM_GPR, 16, number of general-purpose registers (2..32)

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous active-high reset
gpr_in  in  NUM_GPR  per-GPR load enable (bit i loads Ri from bus)
pc_in, ir_in, hi_in, lo_in, y_in, mar_in, mdr_in  in  1 each  special-register load enables
mdr_read  in  1  when mdr_in=1, MDR loads mem_data_in instead of bus
mem_data_in  in  DATA_W  memory read data
src_sel  in  NUM_GPR+6  one-hot bus source; [NUM_GPR-1:0]=GPRs, then HI, LO, ZHI, ZLO, PC, MDR
alu_op  in  4  ALU operation code
alu_start  in  1  start ALU op; operands Y (A) and bus_out (B)
alu_busy  out  1  multi-cycle op in progress
alu_done  out  1  one-cycle pulse: Z updated
div0  out  1  last DIV had zero divisor
bus_conflict  out  1  more than one src_sel bit set (combinational)
bus_out  out  DATA_W  current bus value
mar_out, ir_out, mdr_out  out  DATA_W each  register contents for memory/control

Behaviour:
- Reset (async, clear=1): all registers, Z, FSM and div0 go to 0; alu_busy=0, alu_done=0. Reset mid-operation aborts the op; no done pulse.
- Bus: combinational. Zero src_sel bits -> bus_out=0. One bit -> that source. Several bits -> lowest-index selected source; bus_conflict=1.
- Register load: at the rising edge, any register with its enable high captures bus_out (MDR: mem_data_in if mdr_read). A register may load the bus it drives in the same cycle (old value onto bus, same value back).
- ZHI/ZLO are written only by the ALU.
- ALU FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: alu_start sampled at edge k.
  - Single-cycle op: Z written at edge k, then DONE.
  - MUL/DIV: operands latched at edge k, busy=1, iterate DATA_W cycles, Z written at edge k+DATA_W, then DONE.
  - DONE: alu_done=1 for exactly one cycle, busy=0, return to IDLE.
  - A back-to-back start while in DONE is accepted.
- alu_start while busy=1 is ignored. Register loads and bus traffic continue during busy. ZHI/ZLO read their old values until the write edge.
- Opcodes (Z = {ZHI,ZLO}; ZHI=0 unless noted; shift amount = B[log2(DATA_W)-1:0]):
  - 0 ADD, 1 SUB (modulo 2^DATA_W), 2 AND, 3 OR
  - 4 SHR logical, 5 SHRA arithmetic, 6 SHL, 7 ROR, 8 ROL
  - 9 MUL: signed A*B, full 2*DATA_W product; ZHI high half, ZLO low half. Shift-add on magnitudes with final sign fix.
  - 10 DIV: signed A/B; ZLO=quotient truncated toward zero, ZHI=remainder with the dividend's sign. Restoring algorithm.
  - 11 NEG B, 12 NOT B
  - 13-15 reserved: Z=0, single-cycle
- DIV with B=0: single-cycle, ZLO=all ones, ZHI=A, div0=1. div0 is cleared by the next accepted alu_start. Most-negative / -1: ZLO=most-negative, ZHI=0, div0=0.

Optional Feature:
GPR0_ZERO_EN: when defined, R0 is hard-wired to zero: gpr_in[0] is ignored and src_sel[0] drives 0 (conflict rule unchanged). When undefined, R0 is an ordinary register.

Test Plan:
- Load R3=0x00000005 (bus from MDR, mdr_read), Y<-R3, R4=0x00000003, start ADD with src R4 -> next cycle alu_done=1, ZLO=0x00000008, ZHI=0.
- Y=0xFFFFFFFE (-2), B=0x00000003, MUL -> busy for 32 cycles, done pulse once, ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA; second start during busy ignored.
- Y=0xFFFFFFF9 (-7), B=2, DIV -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF. Then B=0 -> done next cycle, ZLO=0xFFFFFFFF, ZHI=0xFFFFFFF9, div0=1; next start clears div0.
- src_sel with R2 and R5 bits set (R2=0x11, R5=0x22) -> bus_out=0x11, bus_conflict=1; src_sel=0 -> bus_out=0, bus_conflict=0.
- Assert clear at cycle 10 of a DIV -> busy=0, no alu_done, all registers 0; a new ADD afterwards completes normally.
- With GPR0_ZERO_EN: write 0xDEADBEEF to R0, drive src_sel[0] -> bus_out=0. Without it -> bus_out=0xDEADBEEF.

Source files
------------

// File: rtl/param_bus_datapath.sv
// Parametrised single-bus CPU datapath: GPR file, special registers, one-hot bus mux, handshaked ALU.
// Optional build macro GPR0_ZERO_EN hard-wires R0 to zero.
module param_bus_datapath #(
    parameter int DATA_W  = 32,
    parameter int NUM_GPR = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [NUM_GPR-1:0]   gpr_in,
    input  logic                 pc_in,
    input  logic                 ir_in,
    input  logic                 hi_in,
    input  logic                 lo_in,
    input  logic                 y_in,
    input  logic                 mar_in,
    input  logic                 mdr_in,
    input  logic                 mdr_read,
    input  logic [DATA_W-1:0]    mem_data_in,
    input  logic [NUM_GPR+5:0]   src_sel,
    input  logic [3:0]           alu_op,
    input  logic                 alu_start,
    output logic                 alu_busy,
    output logic                 alu_done,
    output logic                 div0,
    output logic                 bus_conflict,
    output logic [DATA_W-1:0]    bus_out,
    output logic [DATA_W-1:0]    mar_out,
    output logic [DATA_W-1:0]    ir_out,
    output logic [DATA_W-1:0]    mdr_out
);

    localparam int SRC_N   = NUM_GPR + 6;
    localparam int SH_W    = $clog2(DATA_W);
    localparam int SRC_HI  = NUM_GPR;
    localparam int SRC_LO  = NUM_GPR + 1;
    localparam int SRC_ZHI = NUM_GPR + 2;
    localparam int SRC_ZLO = NUM_GPR + 3;
    localparam int SRC_PC  = NUM_GPR + 4;
    localparam int SRC_MDR = NUM_GPR + 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4,  OP_SHRA = 4'd5, OP_SHL = 4'd6,  OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8,  OP_MUL = 4'd9,  OP_DIV = 4'd10, OP_NEG = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;

    localparam logic [SH_W-1:0] LAST_ITER = SH_W'(DATA_W - 1);

    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] hi, lo, pc, ir, y, mar, mdr, zhi, zlo;
    logic [NUM_GPR-1:0] gpr_en;

    logic [1:0]          state;
    logic [SH_W-1:0]     iter;
    logic [2*DATA_W-1:0] work;
    logic [DATA_W-1:0]   mag_b;
    logic                neg_q, neg_r;

    // ---------------- bus mux ----------------
    logic [DATA_W-1:0] src_val [SRC_N];

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) src_val[i] = gpr[i];
        src_val[SRC_HI]  = hi;
        src_val[SRC_LO]  = lo;
        src_val[SRC_ZHI] = zhi;
        src_val[SRC_ZLO] = zlo;
        src_val[SRC_PC]  = pc;
        src_val[SRC_MDR] = mdr;
    end

    // Walking from the top down lets the lowest selected index win.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bus_out = '0;
        for (int i = SRC_N - 1; i >= 0; i--) begin
            if (src_sel[i]) bus_out = src_val[i];
        end
    end

    assign bus_conflict = (src_sel & (src_sel - SRC_N'(1))) != '0;

    // ---------------- register file ----------------
`ifdef GPR0_ZERO_EN
    // R0 never loads, so it holds its reset value of zero forever.
    logic unused_r0_en;
    assign unused_r0_en = gpr_in[0];
    assign gpr_en       = {gpr_in[NUM_GPR-1:1], 1'b0};
`else
    assign gpr_en = gpr_in;
`endif

    // NOTE: the GPR file is small and must clear on reset, so it is built from flops, not RAM.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gpr_en[i]) gpr[i] <= bus_out;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hi  <= '0;
            lo  <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            mar <= '0;
            mdr <= '0;
        end else begin
            if (hi_in)  hi  <= bus_out;
            if (lo_in)  lo  <= bus_out;
            if (pc_in)  pc  <= bus_out;
            if (ir_in)  ir  <= bus_out;
            if (y_in)   y   <= bus_out;
            if (mar_in) mar <= bus_out;
            if (mdr_in) mdr <= mdr_read ? mem_data_in : bus_out;
        end
    end

    assign mar_out = mar;
    assign ir_out  = ir;
    assign mdr_out = mdr;

    // ---------------- single-cycle ALU ----------------
    logic [DATA_W-1:0]   op_a, op_b, quick_lo, shra_res;
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] dbl, ror_dbl, rol_dbl;

    assign op_a = y;
    assign op_b = bus_out;
    assign sh   = op_b[SH_W-1:0];

    always_comb begin
        dbl      = {op_a, op_a};
        ror_dbl  = dbl >> sh;
        rol_dbl  = dbl << sh;
        shra_res = $signed(op_a) >>> sh;
        case (alu_op)
            OP_ADD:  quick_lo = op_a + op_b;
            OP_SUB:  quick_lo = op_a - op_b;
            OP_AND:  quick_lo = op_a & op_b;
            OP_OR:   quick_lo = op_a | op_b;
            OP_SHR:  quick_lo = op_a >> sh;
            OP_SHRA: quick_lo = shra_res;
            OP_SHL:  quick_lo = op_a << sh;
            OP_ROR:  quick_lo = ror_dbl[DATA_W-1:0];
            OP_ROL:  quick_lo = rol_dbl[2*DATA_W-1:DATA_W];
            OP_NEG:  quick_lo = -op_b;
            OP_NOT:  quick_lo = ~op_b;
            default: quick_lo = '0;
        endcase
    end

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    // ---------------- iterative MUL / DIV steps ----------------
    // work holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [2*DATA_W-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, work[2*DATA_W-1:DATA_W]} + {1'b0, (work[0] ? mag_b : '0)};
        mul_next  = {mul_sum, work[DATA_W-1:1]};
        div_shift = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_next  = div_diff[DATA_W]
                  ? {div_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0}
                  : {div_diff[DATA_W-1:0],  work[DATA_W-2:0], 1'b1};
    end

    // ---------------- ALU control FSM ----------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
            iter  <= '0;
            work  <= '0;
            mag_b <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            zhi   <= '0;
            zlo   <= '0;
            div0  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (alu_start) begin
                        div0  <= 1'b0;
                        iter  <= '0;
                        work  <= {{DATA_W{1'b0}}, magnitude(op_a)};
                        mag_b <= magnitude(op_b);
                        neg_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                        neg_r <= op_a[DATA_W-1];
                        if (alu_op == OP_MUL) begin
                            state <= S_MUL;
                        end else if (alu_op == OP_DIV && op_b != '0) begin
                            state <= S_DIV;
                        end else if (alu_op == OP_DIV) begin
                            zhi   <= op_a;
                            zlo   <= '1;
                            div0  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            zhi   <= '0;
                            zlo   <= quick_lo;
                            state <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    work <= mul_next;
                    iter <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        {zhi, zlo} <= neg_q ? -mul_next : mul_next;
                        state      <= S_DONE;
                    end
                end
                S_DIV: begin
                    work <= div_next;
                    iter <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        zlo   <= neg_q ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
                        zhi   <= neg_r ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign alu_busy = (state == S_MUL) || (state == S_DIV);
    assign alu_done = (state == S_DONE);

endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath: directed and random ALU ops against an arithmetic reference model.
module tb_param_bus_datapath;

    localparam int DW  = 32;
    localparam int NG  = 16;
    localparam int NS  = NG + 6;
    localparam int SHW = $clog2(DW);
    localparam int HI = NG, LO = NG + 1, ZHI = NG + 2, ZLO = NG + 3, PC = NG + 4, MDR = NG + 5;

    logic            clock, clear;
    logic [NG-1:0]   gpr_in;
    logic            pc_in, ir_in, hi_in, lo_in, y_in, mar_in, mdr_in, mdr_read;
    logic [DW-1:0]   mem_data_in;
    logic [NS-1:0]   src_sel;
    logic [3:0]      alu_op;
    logic            alu_start;
    logic            alu_busy, alu_done, div0, bus_conflict;
    logic [DW-1:0]   bus_out, mar_out, ir_out, mdr_out;

    param_bus_datapath #(.DATA_W(DW), .NUM_GPR(NG)) dut (
        .clock(clock), .clear(clear), .gpr_in(gpr_in),
        .pc_in(pc_in), .ir_in(ir_in), .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_read(mdr_read), .mem_data_in(mem_data_in),
        .src_sel(src_sel), .alu_op(alu_op), .alu_start(alu_start),
        .alu_busy(alu_busy), .alu_done(alu_done), .div0(div0), .bus_conflict(bus_conflict),
        .bus_out(bus_out), .mar_out(mar_out), .ir_out(ir_out), .mdr_out(mdr_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] zhi;
        logic [DW-1:0] zlo;
        logic          d0;
        int            lat;
        int            ck;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic obs_hi   = 1'b0;
    logic obs_lo   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] zhi, input logic [DW-1:0] zlo,
                                input logic d0, input int lat);
        exp_t e;
        e.zhi = zhi; e.zlo = zlo; e.d0 = d0; e.lat = lat; e.ck = 0;
        return e;
    endfunction

    // Reference model: plain 64-bit integer arithmetic on the opcode definitions.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint p, q, r;
        int     sh = int'(b[SHW-1:0]);
        e = mk('0, '0, 1'b0, 0);
        case (op)
            4'd0:  e.zlo = a + b;
            4'd1:  e.zlo = a - b;
            4'd2:  e.zlo = a & b;
            4'd3:  e.zlo = a | b;
            4'd4:  e.zlo = a >> sh;
            4'd5:  begin p = sa >>> sh; e.zlo = p[DW-1:0]; end
            4'd6:  e.zlo = a << sh;
            4'd7:  begin p = (ua >> sh) | (ua << (DW - sh)); e.zlo = p[DW-1:0]; end
            4'd8:  begin p = (ua << sh) | (ua >> (DW - sh)); e.zlo = p[DW-1:0]; end
            4'd9:  begin p = sa * sb; e.zhi = p[2*DW-1:DW]; e.zlo = p[DW-1:0]; e.lat = DW; end
            4'd10: begin
                if (b == '0) begin
                    e.zlo = '1; e.zhi = a; e.d0 = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e.zlo = q[DW-1:0]; e.zhi = r[DW-1:0]; e.lat = DW;
                end
            end
            4'd11: e.zlo = -b;
            4'd12: e.zlo = ~b;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [NS-1:0] oh(input int i);
        logic [NS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [DW-1:0] v);
        mem_data_in = v; mdr_in = 1'b1; mdr_read = 1'b1;
        tick();
        mdr_in = 1'b0; mdr_read = 1'b0;
    endtask

    task automatic load_gpr(input int i, input logic [DW-1:0] v);
        load_mdr(v);
        src_sel = oh(MDR); gpr_in = NG'(1) << i;
        tick();
        gpr_in = '0; src_sel = '0;
    endtask

    task automatic load_y(input int src);
        src_sel = oh(src); y_in = 1'b1;
        tick();
        y_in = 1'b0; src_sel = '0;
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        while (!alu_done && n < DW + 8) begin
            alu_start = (poke && n == 4);
            tick();
            n++;
        end
        alu_start = 1'b0;
        if (!alu_done) begin
            check("done_timeout", alu_done, 1);
            if (sb_q.size() != 0) void'(sb_q.pop_back());
        end
    endtask

    task automatic observe();
        src_sel = oh(ZHI); obs_hi = 1'b1;
        tick();
        obs_hi = 1'b0; src_sel = oh(ZLO); obs_lo = 1'b1;
        tick();
        obs_lo = 1'b0; src_sel = '0;
    endtask

    // Y must already hold A and src must drive B.
    task automatic start_op(input logic [3:0] op, input int src, input exp_t e, input bit poke);
        exp_t x = e;
        src_sel = oh(src); alu_op = op; alu_start = 1'b1;
        x.ck = cyc + 1;
        sb_q.push_back(x);
        tick();
        alu_start = 1'b0; src_sel = '0;
        wait_done(poke);
        observe();
    endtask

    task automatic run_alu(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op,
                           input exp_t e, input bit poke);
        load_mdr(a);
        load_y(MDR);
        load_mdr(b);
        start_op(op, MDR, e, poke);
    endtask

    // Monitor: pairs each done pulse with the oldest expectation and checks Z when the bench reads it.
    initial begin
        int busy_cnt = 0;
        cur = mk('0, '0, 1'b0, 0);
        forever begin
            @(negedge clock);
            if (clear) begin
                busy_cnt = 0;
            end else begin
                if (alu_busy) busy_cnt++;
                if (alu_done) begin
                    if (sb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done at t=%0t: got alu_done=1, expected 0", $time);
                    end else begin
                        cur = sb_q.pop_front();
                        check("done_latency", 64'(cyc - cur.ck), 64'(cur.lat));
                        check("busy_cycles", 64'(busy_cnt), 64'(cur.lat));
                        check("div0", div0, cur.d0);
                    end
                    busy_cnt = 0;
                end
                if (obs_hi) check("zhi", bus_out, cur.zhi);
                if (obs_lo) check("zlo", bus_out, cur.zlo);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at t=%0t: got no finish, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, b;
        logic [3:0]    op;
        clear = 1'b1; gpr_in = '0; pc_in = 0; ir_in = 0; hi_in = 0; lo_in = 0; y_in = 0;
        mar_in = 0; mdr_in = 0; mdr_read = 0; mem_data_in = '0; src_sel = '0;
        alu_op = '0; alu_start = 0;
        tick(); tick();
        src_sel = oh(7);
        #1;
        check("rst_busy", alu_busy, 0);
        check("rst_done", alu_done, 0);
        check("rst_div0", div0, 0);
        check("rst_bus_r7", bus_out, 0);
        check("rst_mdr", mdr_out, 0);
        src_sel = '0;
        clear = 1'b0;
        tick();

        // ADD through the GPR path
        load_gpr(3, 32'h0000_0005);
        load_y(3);
        load_gpr(4, 32'h0000_0003);
        start_op(4'd0, 4, mk(32'h0, 32'h8, 1'b0, 0), 1'b0);

        // MUL with a start poked while busy
        run_alu(32'hFFFF_FFFE, 32'h3, 4'd9, mk(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, DW), 1'b1);

        // DIV cases
        run_alu(32'hFFFF_FFF9, 32'h2, 4'd10, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DW), 1'b0);
        run_alu(32'hFFFF_FFF9, 32'h0, 4'd10, mk(32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0), 1'b0);
        run_alu(32'h1, 32'h1, 4'd0, mk(32'h0, 32'h2, 1'b0, 0), 1'b0);
        run_alu(32'h8000_0000, 32'hFFFF_FFFF, 4'd10, mk(32'h0, 32'h8000_0000, 1'b0, DW), 1'b0);
        run_alu(32'h8765_4321, 32'h4, 4'd7, mk(32'h0, 32'h1876_5432, 1'b0, 0), 1'b0);
        run_alu(32'h8000_0000, 32'h1F, 4'd5, mk(32'h0, 32'hFFFF_FFFF, 1'b0, 0), 1'b0);

        // Bus conflict
        load_gpr(2, 32'h11);
        load_gpr(5, 32'h22);
        src_sel = oh(2) | oh(5);
        #1;
        check("conflict_bus", bus_out, 32'h11);
        check("conflict_flag", bus_conflict, 1);
        src_sel = oh(5);
        #1;
        check("single_bus", bus_out, 32'h22);
        check("single_flag", bus_conflict, 0);
        src_sel = '0;
        #1;
        check("empty_bus", bus_out, 0);
        check("empty_flag", bus_conflict, 0);

        // R0 behaviour
        load_gpr(0, 32'hDEAD_BEEF);
        src_sel = oh(0);
        #1;
`ifdef GPR0_ZERO_EN
        check("r0_bus", bus_out, 32'h0);
`else
        check("r0_bus", bus_out, 32'hDEAD_BEEF);
`endif
        src_sel = '0;

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = DW'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            run_alu(a, b, op, model(a, b, op), 1'b0);
        end

        // Reset in the middle of a DIV
        load_mdr(32'h55);
        src_sel = oh(MDR);
        pc_in = 1; hi_in = 1; lo_in = 1; mar_in = 1; ir_in = 1;
        tick();
        pc_in = 0; hi_in = 0; lo_in = 0; mar_in = 0; ir_in = 0;
        load_y(MDR);
        load_mdr(32'h3);
        src_sel = oh(MDR); alu_op = 4'd10; alu_start = 1'b1;
        tick();
        alu_start = 1'b0; src_sel = '0;
        for (int i = 0; i < 9; i++) tick();
        check("busy_before_clear", alu_busy, 1);
        clear = 1'b1;
        #1;
        check("clr_busy", alu_busy, 0);
        check("clr_done", alu_done, 0);
        check("clr_div0", div0, 0);
        check("clr_mar", mar_out, 0);
        check("clr_ir", ir_out, 0);
        check("clr_mdr", mdr_out, 0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_sel = oh(i);
            #1;
            check($sformatf("clr_src%0d", i), bus_out, 0);
        end
        src_sel = '0;
        for (int i = 0; i < DW; i++) tick();
        run_alu(32'h7, 32'h9, 4'd0, mk(32'h0, 32'h10, 1'b0, 0), 1'b0);

        tick(); tick();
        check("queue_drained", 64'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
